mips_processor: RTL and testbench
=================================

Name: mips_processor

Overview:
- Single-cycle 32-bit MIPS-subset CPU; every instruction completes in exactly one clock.
- Self-contained top: internal instruction memory, data memory, register file and control.
- Programs are preloaded into the instruction memory by hierarchical $readmemb.
- Verification reads architectural state through fixed hierarchical paths.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes.
- DMEM_BYTES, 1024, data memory size in bytes.
- RESET_PC, 32'h0000_0000, PC value while reset is asserted and on release.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc  output  32  current program counter, for debug.

Behaviour:
- Required hierarchy, which benches access directly:
  - instance IFU contains imemory.storage.bytes: reg [7:0] array [0:IMEM_BYTES-1], big-endian words, loaded via $readmemb.
  - instance registers contains registers: reg [31:0] array [0:31].
- Reset (rst_n=0, asynchronous): PC=RESET_PC, all 32 registers = 0. Memories are not cleared.
- Each rising edge with rst_n=1 does exactly one instruction:
  - fetch at PC, decode, execute;
  - write back to the register file and/or data memory;
  - update PC.
- Register $0 always reads 0; writes to it are discarded.
- Instruction set:
  - R-type (op 0): add/addu 0x20/0x21, sub/subu 0x22/0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, jr 0x08.
  - I-type: addi/addiu 0x08/0x09 and slti 0x0A use the sign-extended immediate. andi 0x0C, ori 0x0D, xori 0x0E use the zero-extended immediate. lui 0x0F.
  - Memory: lw 0x23, sw 0x2B.
  - Branches: beq 0x04, bne 0x05.
  - Jumps: j 0x02, jal 0x03 (writes PC+4 to $31).
- Arithmetic: 32-bit two's complement wrap. No overflow traps, so add behaves like addu.
- Next PC:
  - default PC+4;
  - taken branch: PC+4 + (sext(imm16)<<2);
  - j/jal: {PC+4[31:28], idx26, 2'b00};
  - jr: rs value.
- beq is taken iff rs==rs_t values are equal; bne is taken iff they differ. An untaken branch falls through to PC+4 with no register write.
- lw/sw address is rs + sext(imm16), word access, big-endian. Low 2 address bits are ignored. Address is taken modulo the memory size.
- Instruction fetch address is also taken modulo IMEM_BYTES.
- Unknown opcode or funct executes as a NOP (PC+4, no writes).
- Register-file reads are combinational. The write happens at the rising edge, so a result becomes visible to the next instruction.
- Reset mid-program: state is cleared immediately; execution restarts at RESET_PC on the first edge after release.

Decomposition:
- Shared package / include holds:
  - opcode and funct constants;
  - ABI register indices (REG_ZERO=0, REG_V0=2, REG_A0=4, REG_A1=5, REG_T0=8, REG_RA=31);
  - ALU operation encodings.
- Sub-modules:
  - register_file, instance name registers;
  - instruction fetch unit, instance IFU, wrapping a byte memory at imemory.storage.
- ALU, control decode and data memory may stay inline.

Test Plan:
- Reset: hold rst_n=0, then release → pc=0 and all registers 0. Assert rst_n mid-run → pc returns to 0 asynchronously.
- ALU program: addi a0,$0,7; addi a1,$0,-2; add t0,a0,a1; slt t1,a1,a0 → after 4 edges a0=7, a1=32'hFFFFFFFE, t0=5, t1=1.
- Branch-taken bne program: a0=0, a1=2, t0=1 after 3–5 edges. The program then loops with bne, adding 2 to a0 until a0==4, then exits → a0=4, a1=2; skipped instructions must not write.
- Branch-not-taken: a0=0, a1=2, then beq a0,a1 over an addi a0,a0,9, followed by addi a0,a0,-9 → final a0=0, a1=2, proving the fall-through path executed.
- Memory: addi t0,$0,0x40; sw a1,4(t0); lw a0,4(t0) with a1=2 → a0=2. Writes to $0 leave it at 0.
- Jumps: j over one instruction, jal then jr $ra → skipped register unchanged, $31 = jal PC+4, and execution resumes after the jal.

Source files
------------

// File: rtl/mips_processor_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: opcodes, function
// codes, ABI register indices, ALU operations and decode selector types.
package mips_processor_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ABI register indices
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_A0   = 5'd4;
    localparam logic [4:0] REG_A1   = 5'd5;
    localparam logic [4:0] REG_T0   = 5'd8;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    // Source of the register write-back value
    typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_LINK } wb_sel_t;

    // Which field names the destination register
    typedef enum logic [1:0] { DST_RT, DST_RD, DST_RA } dst_sel_t;

    function automatic logic [31:0] sign_extend16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/mips_processor_byte_mem.sv
// Byte-array memory with a 32-bit big-endian port: the byte at the lowest
// address carries bits 31:24. Combinational read, write on the rising edge.
module mips_processor_byte_mem #(
    parameter int BYTES = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(BYTES)-1:0]   addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);
    localparam int AW = $clog2(BYTES);

    logic [7:0] bytes [0:BYTES-1];

    // Assemble the big-endian word one byte lane at a time
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata[31-8*gi -: 8] = bytes[addr + AW'(gi)];
        end
    endgenerate

    // Store all four lanes of a word write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                bytes[addr + AW'(k)] <= wdata[31-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/mips_processor_ifu.sv
// Instruction fetch unit: read-only instruction memory indexed by PC word.
module mips_processor_ifu #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic                            clk,
    input  logic [$clog2(IMEM_BYTES)-3:0]   fetch_word,
    output logic [31:0]                     instr
);

    // Program image is preloaded from outside; the core never writes it
    mips_processor_word_mem #(.BYTES(IMEM_BYTES)) imemory (
        .clk       (clk),
        .we        (1'b0),
        .word_addr (fetch_word),
        .wdata     (32'h0),
        .rdata     (instr)
    );

endmodule

// File: rtl/mips_processor_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port.
// Register $0 is never written, so it always reads zero.
module mips_processor_regfile
    import mips_processor_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] registers [0:31];

    assign rs_data = registers[rs_addr];
    assign rt_data = registers[rt_addr];

    // Clear everything on reset; otherwise commit one write per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (wr_en && (wr_addr != REG_ZERO)) begin
            registers[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/mips_processor_word_mem.sv
// Word-addressed view of a byte memory. Only the word index is taken, so the
// low two byte-address bits and anything above the memory size are dropped.
module mips_processor_word_mem #(
    parameter int BYTES = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(BYTES)-3:0]   word_addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);

    mips_processor_byte_mem #(.BYTES(BYTES)) storage (
        .clk   (clk),
        .we    (we),
        .addr  ({word_addr, 2'b00}),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: rtl/mips_processor.sv
// Single-cycle MIPS-subset CPU: fetch, decode, execute, memory access and
// write-back all happen within one clock. Data memory and ALU live here.
module mips_processor
    import mips_processor_pkg::*;
#(
    parameter int          IMEM_BYTES = 1024,
    parameter int          DMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc
);
    localparam int IW = $clog2(IMEM_BYTES);
    localparam int DW = $clog2(DMEM_BYTES);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] instr;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jump_index;

    logic [31:0] rs_val, rt_val;
    logic [31:0] imm_ext, alu_b, alu_result, load_data, wr_data;
    logic [4:0]  wr_addr;

    // Decode outputs
    logic     reg_write, alu_src_imm, imm_zero_ext, mem_write;
    logic     branch_eq, branch_ne, jump, jump_reg;
    wb_sel_t  wb_sel;
    dst_sel_t dst_sel;
    alu_op_t  alu_op;

    assign pc       = pc_reg;
    assign pc_plus4 = pc_reg + 32'd4;

    mips_processor_ifu #(.IMEM_BYTES(IMEM_BYTES)) IFU (
        .clk        (clk),
        .fetch_word (pc_reg[IW-1:2]),
        .instr      (instr)
    );

    assign opcode     = instr[31:26];
    assign rs         = instr[25:21];
    assign rt         = instr[20:16];
    assign rd         = instr[15:11];
    assign shamt      = instr[10:6];
    assign funct      = instr[5:0];
    assign imm16      = instr[15:0];
    assign jump_index = instr[25:0];

    mips_processor_regfile registers (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_val),
        .rt_data (rt_val),
        .wr_en   (reg_write),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Control decode; unknown opcodes/functs fall out as all-zero controls (NOP)
    always_comb begin
        reg_write    = 1'b0;
        alu_src_imm  = 1'b0;
        imm_zero_ext = 1'b0;
        mem_write    = 1'b0;
        branch_eq    = 1'b0;
        branch_ne    = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
        wb_sel       = WB_ALU;
        dst_sel      = DST_RT;
        alu_op       = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                dst_sel   = DST_RD;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    FN_JR: begin
                        reg_write = 1'b0;
                        jump_reg  = 1'b1;
                    end
                    default:         reg_write = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_ADD;
            end
            OP_SLTI: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_SLT;
            end
            OP_ANDI: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_AND;
            end
            OP_ORI: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_OR;
            end
            OP_XORI: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_XOR;
            end
            OP_LUI: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_LUI;
            end
            OP_LW: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; wb_sel = WB_MEM;
            end
            OP_SW: begin
                mem_write = 1'b1; alu_src_imm = 1'b1;
            end
            OP_BEQ: branch_eq = 1'b1;
            OP_BNE: branch_ne = 1'b1;
            OP_J:   jump = 1'b1;
            OP_JAL: begin
                jump = 1'b1; reg_write = 1'b1; dst_sel = DST_RA; wb_sel = WB_LINK;
            end
            default: ;
        endcase
    end

    assign imm_ext = imm_zero_ext ? {16'h0, imm16} : sign_extend16(imm16);
    assign alu_b   = alu_src_imm ? imm_ext : rt_val;

    // ALU; shifts move the rt operand by the shamt field
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:  alu_result = rs_val + alu_b;
            ALU_SUB:  alu_result = rs_val - alu_b;
            ALU_AND:  alu_result = rs_val & alu_b;
            ALU_OR:   alu_result = rs_val | alu_b;
            ALU_XOR:  alu_result = rs_val ^ alu_b;
            ALU_NOR:  alu_result = ~(rs_val | alu_b);
            ALU_SLT:  alu_result = {31'h0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLTU: alu_result = {31'h0, rs_val < alu_b};
            ALU_SLL:  alu_result = alu_b << shamt;
            ALU_SRL:  alu_result = alu_b >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(alu_b) >>> shamt);
            ALU_LUI:  alu_result = {alu_b[15:0], 16'h0};
            default:  alu_result = '0;
        endcase
    end

    // Data memory: word access at rs + sext(imm), wrapped to the memory size
    mips_processor_word_mem #(.BYTES(DMEM_BYTES)) dmem (
        .clk       (clk),
        .we        (mem_write),
        .word_addr (alu_result[DW-1:2]),
        .wdata     (rt_val),
        .rdata     (load_data)
    );

    // Write-back destination and value selection
    always_comb begin
        wr_addr = rt;
        wr_data = alu_result;
        case (dst_sel)
            DST_RD:  wr_addr = rd;
            DST_RA:  wr_addr = REG_RA;
            default: wr_addr = rt;
        endcase
        case (wb_sel)
            WB_MEM:  wr_data = load_data;
            WB_LINK: wr_data = pc_plus4;
            default: wr_data = alu_result;
        endcase
    end

    // Next-PC selection: jr, j/jal, taken branch, else sequential
    always_comb begin
        pc_next = pc_plus4;
        if (jump_reg) begin
            pc_next = rs_val;
        end else if (jump) begin
            pc_next = {pc_plus4[31:28], jump_index, 2'b00};
        end else if ((branch_eq && (rs_val == rt_val)) || (branch_ne && (rs_val != rt_val))) begin
            pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
        end
    end

    // Program counter with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: tb/tb_mips_processor.sv
// Directed bench for mips_processor: loads small programs straight into the
// instruction memory, runs a fixed number of edges and checks registers and
// PC against expectations queued when each program is started.
module tb_mips_processor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;

    mips_processor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc    (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int A0 = 4, A1 = 5, T0 = 8, T1 = 9, T2 = 10, T3 = 11, T4 = 12,
                   T5 = 13, T6 = 14, T7 = 15, S0 = 16, S1 = 17, S2 = 18, S3 = 19, RA = 31;
    localparam logic [31:0] HALT = 32'h1000_FFFF;   // beq $0,$0,-1

    typedef struct {
        string       tag;
        bit          is_pc;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] rtype(int rs_i, int rt_i, int rd_i, int sh, int fn);
        return {6'h00, 5'(rs_i), 5'(rt_i), 5'(rd_i), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs_i, int rt_i, int imm);
        return {6'(op), 5'(rs_i), 5'(rt_i), 16'(imm)};
    endfunction

    function automatic logic [31:0] jtype(int op, int word_idx);
        return {6'(op), 26'(word_idx)};
    endfunction

    task automatic load_prog();
        logic [31:0] w;
        for (int a = 0; a < 1024; a++) dut.IFU.imemory.storage.bytes[a] = 8'h00;
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            for (int b = 0; b < 4; b++) dut.IFU.imemory.storage.bytes[4*i+b] = w[31-8*b -: 8];
        end
        prog.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_reg(string tag, int idx, logic [31:0] v);
        sb.push_back('{tag, 1'b0, idx, v});
    endtask

    task automatic exp_pc(string tag, logic [31:0] v);
        sb.push_back('{tag, 1'b1, 0, v});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.is_pc ? pc : dut.registers.registers[e.idx];
            n_checks++;
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
            $display("check %s: observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    initial begin
        rst_n = 1'b0;

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        #1;
        exp_pc("reset_pc", 32'h0);
        for (int r = 0; r < 32; r++) exp_reg($sformatf("reset_r%0d", r), r, 32'h0);
        drain();

        // ---- ALU program ----
        prog.push_back(itype(8, 0, A0, 7));
        prog.push_back(itype(8, 0, A1, 16'hFFFE));
        prog.push_back(rtype(A0, A1, T0, 0, 8'h20));
        prog.push_back(rtype(A1, A0, T1, 0, 8'h2A));
        prog.push_back(rtype(A0, A1, T2, 0, 8'h2B));
        prog.push_back(itype(8'h0F, 0, T3, 16'h8001));
        prog.push_back(rtype(0, T3, T4, 4, 8'h03));
        prog.push_back(rtype(0, T3, T5, 4, 8'h02));
        prog.push_back(rtype(A0, 0, T6, 0, 8'h27));
        prog.push_back(itype(8'h0E, A0, T7, 16'hFFFF));
        prog.push_back(rtype(A0, A1, S0, 0, 8'h22));
        prog.push_back(itype(8'h0C, A1, S1, 16'h8003));
        prog.push_back(rtype(0, A0, S2, 28, 8'h00));
        prog.push_back(itype(8, 0, 0, 5));
        prog.push_back(itype(8'h0A, A1, S3, 16'hFFFF));
        prog.push_back(HALT);
        load_prog();
        do_reset();
        exp_pc("alu_pc4", 32'd16);
        exp_reg("alu_a0", A0, 32'd7);
        exp_reg("alu_a1", A1, 32'hFFFF_FFFE);
        exp_reg("alu_add", T0, 32'd5);
        exp_reg("alu_slt", T1, 32'd1);
        run(4);
        drain();
        exp_pc("alu_pc_end", 32'd60);
        exp_reg("alu_sltu", T2, 32'd1);
        exp_reg("alu_lui", T3, 32'h8001_0000);
        exp_reg("alu_sra", T4, 32'hF800_1000);
        exp_reg("alu_srl", T5, 32'h0800_1000);
        exp_reg("alu_nor", T6, 32'hFFFF_FFF8);
        exp_reg("alu_xori_zext", T7, 32'h0000_FFF8);
        exp_reg("alu_sub", S0, 32'd9);
        exp_reg("alu_andi_zext", S1, 32'h0000_8002);
        exp_reg("alu_sll", S2, 32'h7000_0000);
        exp_reg("alu_zero_reg", 0, 32'h0);
        exp_reg("alu_slti", S3, 32'd1);
        run(11);
        drain();
        exp_pc("alu_halt_pc", 32'd60);
        run(3);
        drain();

        // ---- Branch-taken loop (bne) ----
        prog.push_back(itype(8, 0, A0, 0));
        prog.push_back(itype(8, 0, A1, 2));
        prog.push_back(itype(8, 0, T0, 1));
        prog.push_back(itype(8, A0, A0, 2));        // 3: loop
        prog.push_back(itype(8, 0, T2, 4));
        prog.push_back(itype(5, A0, T2, 16'hFFFD)); // bne a0,t2,loop
        prog.push_back(itype(8, T3, T3, 1));        // fall-through counter
        prog.push_back(itype(4, 0, 0, 1));          // beq $0,$0 over next
        prog.push_back(itype(8, 0, A1, 99));        // skipped
        prog.push_back(HALT);
        load_prog();
        do_reset();
        exp_pc("bne_pc3", 32'd12);
        exp_reg("bne_a0_init", A0, 32'd0);
        exp_reg("bne_a1_init", A1, 32'd2);
        exp_reg("bne_t0_init", T0, 32'd1);
        run(3);
        drain();
        exp_pc("bne_pc_end", 32'd36);
        exp_reg("bne_a0_final", A0, 32'd4);
        exp_reg("bne_a1_final", A1, 32'd2);
        exp_reg("bne_fallthru_once", T3, 32'd1);
        run(20);
        drain();

        // ---- Branch-not-taken (beq) and unknown instructions ----
        prog.push_back(itype(8, 0, A0, 0));
        prog.push_back(itype(8, 0, A1, 2));
        prog.push_back(itype(4, A0, A1, 1));
        prog.push_back(itype(8, A0, A0, 9));
        prog.push_back(itype(8, A0, A0, 16'hFFF7));
        prog.push_back(32'hFFFF_FFFF);
        prog.push_back(rtype(A0, A1, RA, 0, 8'h3F));
        prog.push_back(HALT);
        load_prog();
        do_reset();
        exp_pc("beq_nt_pc4", 32'd16);
        exp_reg("beq_nt_a0_mid", A0, 32'd9);
        run(4);
        drain();
        exp_pc("beq_nt_pc_end", 32'd28);
        exp_reg("beq_nt_a0_final", A0, 32'd0);
        exp_reg("beq_nt_a1_final", A1, 32'd2);
        exp_reg("unknown_nop_ra", RA, 32'd0);
        run(5);
        drain();

        // ---- Memory ----
        prog.push_back(itype(8, 0, A1, 2));
        prog.push_back(itype(8, 0, T0, 16'h0040));
        prog.push_back(itype(8'h2B, T0, A1, 4));     // sw a1,4(t0)
        prog.push_back(itype(8'h23, T0, A0, 4));     // lw a0,4(t0)
        prog.push_back(itype(8'h23, T0, 0, 4));      // lw $0,4(t0)
        prog.push_back(itype(8, 0, T1, 16'h0444));
        prog.push_back(itype(8'h23, T1, T2, 0));     // wraps to 0x44
        prog.push_back(itype(8'h23, T0, T3, 7));     // 0x47 -> word 0x44
        prog.push_back(HALT);
        load_prog();
        do_reset();
        exp_pc("mem_pc_end", 32'd32);
        exp_reg("mem_lw", A0, 32'd2);
        exp_reg("mem_zero_reg", 0, 32'd0);
        exp_reg("mem_wrap", T2, 32'd2);
        exp_reg("mem_unaligned", T3, 32'd2);
        run(12);
        drain();

        // ---- Jumps ----
        prog.push_back(itype(8, 0, A0, 1));
        prog.push_back(jtype(2, 3));
        prog.push_back(itype(8, 0, A0, 5));          // skipped by j
        prog.push_back(jtype(3, 6));                 // jal
        prog.push_back(itype(8, 0, A1, 7));          // after return
        prog.push_back(HALT);
        prog.push_back(itype(8, 0, T0, 3));
        prog.push_back(rtype(RA, 0, 0, 0, 8'h08));   // jr $ra
        load_prog();
        do_reset();
        exp_pc("j_target", 32'd12);
        run(2);
        drain();
        exp_pc("jal_target", 32'd24);
        exp_reg("jal_link", RA, 32'd16);
        run(1);
        drain();
        exp_pc("jmp_pc_end", 32'd20);
        exp_reg("j_skipped_a0", A0, 32'd1);
        exp_reg("jr_resume_a1", A1, 32'd7);
        exp_reg("jal_sub_t0", T0, 32'd3);
        exp_reg("jal_ra_final", RA, 32'd16);
        run(6);
        drain();

        // ---- Asynchronous reset mid-run ----
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_pc("async_rst_pc", 32'd0);
        exp_reg("async_rst_ra", RA, 32'd0);
        exp_reg("async_rst_a0", A0, 32'd0);
        drain();
        exp_pc("rst_hold_pc", 32'd0);
        run(2);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc("restart_pc", 32'd4);
        exp_reg("restart_a0", A0, 32'd1);
        run(1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
